// File: rtl/uart_rx_oversample.sv
// 8N1-style UART receiver driven by a 16x (OVERSAMPLE) tick, mid-bit sampling, valid/ready output.
// Optional parity bit compiled in with `define UART_RX_PARITY_EN.
module uart_rx_oversample #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic                 rx_meta_q, rx_meta_d;
    logic                 rx_s_q, rx_s_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic                 busy_q, busy_d;
    logic                 commit;
    logic                 handshake;
`ifdef UART_RX_PARITY_EN
    logic                 par_q, par_d;
    logic                 parity_err_q, parity_err_d;
`else
    logic                 unused_parity_sense;
    assign unused_parity_sense = (PARITY_ODD != 0);
`endif

    always_comb begin
        rx_meta_d   = rx;
        rx_s_d      = rx_meta_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shreg_d     = shreg_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        frame_err_d = frame_err_q;
        overrun_d   = overrun_q;
        commit      = 1'b0;
        handshake   = rx_valid_q & rx_ready;
`ifdef UART_RX_PARITY_EN
        par_d        = par_q;
        parity_err_d = parity_err_q;
`endif

        if (handshake) begin
            rx_valid_d = 1'b0;
            overrun_d  = 1'b0;
        end

        if (tick) begin
            case (state_q)
                S_IDLE: begin
                    if (!rx_s_q) begin
                        state_d = S_START;
                        cnt_d   = '0;
                    end
                end
                S_START: begin
                    // Mid start bit: a high line here means the edge was a glitch.
                    if (cnt_q == CNT_HALF) begin
                        cnt_d = '0;
                        idx_d = '0;
                        state_d = rx_s_q ? S_IDLE : S_DATA;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        shreg_d = {rx_s_q, shreg_q[DATA_BITS-1:1]};
                        idx_d   = idx_q + 1'b1;
                        if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_STOP;
`endif
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        par_d   = rx_s_q;
                        state_d = S_STOP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        commit  = 1'b1;
                        state_d = rx_s_q ? S_IDLE : S_BREAK;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_BREAK: begin
                    // A held-low line yields one framing-error word, then waits for idle.
                    if (rx_s_q) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (commit) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d   = shreg_q;
                frame_err_d = ~rx_s_q;
                rx_valid_d  = 1'b1;
`ifdef UART_RX_PARITY_EN
                parity_err_d = ((^shreg_q) ^ par_q) != 1'(PARITY_ODD);
`endif
            end else begin
                overrun_d = 1'b1;
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            cnt_q       <= '0;
            idx_q       <= '0;
            shreg_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rx_meta_q   <= rx_meta_d;
            rx_s_q      <= rx_s_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shreg_q     <= shreg_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
`ifdef UART_RX_PARITY_EN
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = busy_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule
